// File: rtl/grf_mp.sv
// Multi-port general register file: NRD combinational reads, two write ports (W1 wins
// on conflict), optional write-to-read bypass, per-register busy scoreboard.
// Define GRF_MP_TRACE_EN to print one trace line per committed write.
module grf_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [31:0]           wpc0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [31:0]           wpc1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic                  set_busy,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [NRD-1:0]        rbusy,
  output logic                  any_busy
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam bit          ZR   = (ZERO_REG != 0);
  localparam bit          BP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              w0_ok;
  logic              w1_ok;

  // A W0 write is lost when W1 targets the same register in the same cycle.
  assign w1_ok = we1 && !(ZR && (wa1 == '0));
  assign w0_ok = we0 && !(ZR && (wa0 == '0)) && !(we1 && (wa1 == wa0));

  // NOTE: every register is cleared by reset because software-visible state must read 0
  // after reset; a plain storage array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (w0_ok) regs_q[wa0] <= wd0;
      if (w1_ok) regs_q[wa1] <= wd1;
    end
  end

  // NOTE: busy_d starts from busy_q so every path assigns it and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) busy_d[i] = 1'b0;
      if (set_busy && (set_addr == ADDR_W'(i)))                         busy_d[i] = 1'b1;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign any_busy = |busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      if (ZR && (addr == '0))               data = '0;
      else if (BP && we1 && (wa1 == addr))  data = wd1;
      else if (BP && we0 && (wa0 == addr))  data = wd0;
    end

    assign rd[k*DATA_W +: DATA_W] = data;
    assign rbusy[k]               = busy_q[addr];
  end

`ifdef GRF_MP_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w0_ok) $display("@%08h: $%2d <= %08h", wpc0, wa0, wd0);
      if (w1_ok) $display("@%08h: $%2d <= %08h", wpc1, wa1, wd1);
    end
  end
`else
  // Trace PCs have no function without the trace build.
  logic unused_pc;
  assign unused_pc = ^{wpc0, wpc1};
`endif

endmodule
